// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the Execute stage
// Shift-add multiply and restoring divide on operand magnitudes, UNROLL bits per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int UNROLL         = 1,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [2:0]                funct3_i,
  input  logic [DATA_WIDTH-1:0]     SrcA_i,
  input  logic [DATA_WIDTH-1:0]     SrcB_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     Result_o,
  output logic [REG_ADDR_WIDTH-1:0] Rd_o,
  output logic                      stall_o
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = DATA_WIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]                state;
  logic [CW-1:0]             count;
  logic [2:0]                op;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      sign_a;
  logic                      sign_b;
  logic [2*W-1:0]            prod;
  logic [2*W-1:0]            mcand;
  logic [W-1:0]              mplier;
  logic [W:0]                rem;

  logic                      a_signed;
  logic                      b_signed;
  logic                      in_sa;
  logic                      in_sb;
  logic                      is_div_in;
  logic                      div_zero;
  logic                      div_ovf;
  logic [W-1:0]              a_mag;
  logic [W-1:0]              b_mag;
  logic [W-1:0]              special_res;

  // Signedness: A is signed for MUL/MULH/MULHSU/DIV/REM, B for all of those but MULHSU.
  always_comb begin
    a_signed    = ~funct3_i[0] | (funct3_i == 3'd1);
    b_signed    = a_signed & (funct3_i != 3'd2);
    in_sa       = a_signed & SrcA_i[W-1];
    in_sb       = b_signed & SrcB_i[W-1];
    a_mag       = in_sa ? -SrcA_i : SrcA_i;
    b_mag       = in_sb ? -SrcB_i : SrcB_i;
    is_div_in   = funct3_i[2];
    div_zero    = is_div_in & (SrcB_i == '0);
    div_ovf     = is_div_in & ~funct3_i[0] & (SrcA_i == MOST_NEG) & (SrcB_i == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = funct3_i[1] ? SrcA_i : '1;
    end else if (div_ovf) begin
      special_res = funct3_i[1] ? '0 : MOST_NEG;
    end
  end

  logic [2*W-1:0] prod_nx;
  logic [2*W-1:0] mcand_nx;
  logic [W-1:0]   mplier_nx;
  logic [W:0]     rem_nx;

  // For divides the quotient shifts in through prod[W-1:0], which starts as the dividend.
  always_comb begin
    prod_nx   = prod;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    rem_nx    = rem;
    for (int u = 0; u < UNROLL; u++) begin
      if (op[2]) begin
        rem_nx           = {rem_nx[W-1:0], prod_nx[W-1]};
        prod_nx[W-1:0]   = {prod_nx[W-2:0], 1'b0};
        if (rem_nx >= {1'b0, mplier}) begin
          rem_nx     = rem_nx - {1'b0, mplier};
          prod_nx[0] = 1'b1;
        end
      end else begin
        if (mplier_nx[0]) begin
          prod_nx = prod_nx + mcand_nx;
        end
        mcand_nx  = mcand_nx << 1;
        mplier_nx = mplier_nx >> 1;
      end
    end
  end

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod_s  = (sign_a ^ sign_b) ? -prod : prod;
    quo_s   = (sign_a ^ sign_b) ? -prod[W-1:0] : prod[W-1:0];
    rem_s   = sign_a ? -rem[W-1:0] : rem[W-1:0];
    fix_res = '0;
    case (op)
      3'd0:                fix_res = prod_s[W-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_s[2*W-1:W];
      3'd4, 3'd5:          fix_res = quo_s;
      default:             fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      count    <= '0;
      op       <= '0;
      rd_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      Result_o <= '0;
      Rd_o     <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op     <= funct3_i;
            rd_q   <= RdE_i;
            sign_a <= in_sa;
            sign_b <= in_sb;
            prod   <= is_div_in ? {{W{1'b0}}, a_mag} : '0;
            mcand  <= {{W{1'b0}}, a_mag};
            mplier <= b_mag;
            rem    <= '0;
            count  <= CW'(N);
            if (div_zero | div_ovf) begin
              Result_o <= special_res;
              Rd_o     <= RdE_i;
              state    <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          prod   <= prod_nx;
          mcand  <= mcand_nx;
          mplier <= mplier_nx;
          rem    <= rem_nx;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          Result_o <= fix_res;
          Rd_o     <= rd_q;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (state != S_IDLE);
  assign done_o  = (state == S_DONE);
  assign stall_o = ((state == S_IDLE) & start_i & ~flush_i) | (state == S_CALC) | (state == S_FIX);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (UNROLL=1 and UNROLL=4 instances)
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic [4:0]  rde = '0;

  logic        busy1, done1, stall1, busy4, done4, stall4;
  logic [31:0] res1, res4;
  logic [4:0]  rd1, rd4;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int stalls1 = 0;
  int stalls4 = 0;
  int c0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
    int          stalls;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1;
  exp_t e4;

  muldiv_unit #(.DATA_WIDTH(32), .UNROLL(1), .REG_ADDR_WIDTH(5)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start1), .funct3_i(funct3),
    .SrcA_i(srca), .SrcB_i(srcb), .RdE_i(rde), .flush_i(flush),
    .busy_o(busy1), .done_o(done1), .Result_o(res1), .Rd_o(rd1), .stall_o(stall1)
  );

  muldiv_unit #(.DATA_WIDTH(32), .UNROLL(4), .REG_ADDR_WIDTH(5)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start4), .funct3_i(funct3),
    .SrcA_i(srca), .SrcB_i(srcb), .RdE_i(rde), .flush_i(flush),
    .busy_o(busy4), .done_o(done4), .Result_o(res4), .Rd_o(rd4), .stall_o(stall4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n || flush) stalls1 = 0;
    else if (stall1) stalls1++;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("u1_spurious_done", {31'b0, done1}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("u1_result", res1, e1.res);
        chk("u1_rd", {27'b0, rd1}, {27'b0, e1.rd});
        chk("u1_done_cycle", 32'(cyc), 32'(e1.due));
        chk("u1_stall_cycles", 32'(stalls1), 32'(e1.stalls));
      end
      stalls1 = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n || flush) stalls4 = 0;
    else if (stall4) stalls4++;
    if (done4) begin
      if (q4.size() == 0) begin
        chk("u4_spurious_done", {31'b0, done4}, 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("u4_result", res4, e4.res);
        chk("u4_rd", {27'b0, rd4}, {27'b0, e4.rd});
        chk("u4_done_cycle", 32'(cyc), 32'(e4.due));
        chk("u4_stall_cycles", 32'(stalls4), 32'(e4.stalls));
      end
      stalls4 = 0;
    end
  end

  task automatic wait_done(input int u);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (u == 4) ? done4 : done1;
    end
    chk("done_within_bound", {31'b0, seen}, 32'd1);
  endtask

  task automatic issue(input int u, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] r, input int lat);
    exp_t e;
    @(posedge clk); #1;
    funct3 = f; srca = a; srcb = b; rde = rd;
    e.res = r; e.rd = rd; e.due = cyc + lat; e.stalls = lat;
    if (u == 4) begin start4 = 1'b1; q4.push_back(e); end
    else begin start1 = 1'b1; q1.push_back(e); end
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    wait_done(u);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #23;
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_done", {31'b0, done1}, 32'd0);
    chk("rst_stall", {31'b0, stall1}, 32'd0);
    chk("rst_result", res1, 32'd0);
    chk("rst_rd", {27'b0, rd1}, 32'd0);
    chk("rst_u4_result", res4, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
    issue(1, 3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
    issue(1, 3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34);
    issue(1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34);
    issue(1, 3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34);
    issue(1, 3'd4, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1);
    issue(1, 3'd7, 32'd5,        32'd0,        5'd10, 32'd5,        1);
    issue(1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    issue(1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1);
    issue(1, 3'd4, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, 34);
    issue(1, 3'd6, 32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 34);
    issue(1, 3'd7, 32'd100,      32'd7,        5'd15, 32'd2,        34);

    issue(4, 3'd4, 32'hFFFFFFF9, 32'd2,        5'd16, 32'hFFFFFFFD, 10);
    issue(4, 3'd6, 32'hFFFFFFF9, 32'd2,        5'd17, 32'hFFFFFFFF, 10);
    issue(4, 3'd7, 32'd100,      32'd7,        5'd18, 32'd2,        10);
    issue(4, 3'd0, 32'd7,        32'hFFFFFFFD, 5'd19, 32'hFFFFFFEB, 10);
    issue(4, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'hFFFFFFFE, 10);

    // Flush during CALC: unit 1 still holds REMU 100/7 = 2 in rd 15
    @(posedge clk); #1;
    funct3 = 3'd5; srca = 32'd1000; srcb = 32'd3; rde = 5'd20; start1 = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
    while (cyc < c0 + 10) begin @(posedge clk); #1; end
    chk("flush_pre_busy", {31'b0, busy1}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy1}, 32'd0);
    chk("flush_stall", {31'b0, stall1}, 32'd0);
    chk("flush_done", {31'b0, done1}, 32'd0);
    chk("flush_result_held", res1, 32'd2);
    chk("flush_rd_held", {27'b0, rd1}, 32'd15);
    repeat (40) @(posedge clk);
    #1;

    // Flush wins over a simultaneous start
    funct3 = 3'd5; srca = 32'd9; srcb = 32'd3; start1 = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", {31'b0, stall1}, 32'd0);
    @(posedge clk); #1;
    start1 = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy1}, 32'd0);

    // start_i raised mid-CALC must not disturb the running MUL 3*4
    @(posedge clk); #1;
    funct3 = 3'd0; srca = 32'd3; srcb = 32'd4; rde = 5'd21; start1 = 1'b1;
    e.res = 32'd12; e.rd = 5'd21; e.due = cyc + 34; e.stalls = 34;
    q1.push_back(e);
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    funct3 = 3'd4; srca = 32'd1; srcb = 32'd0; rde = 5'd22; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1);

    // Asynchronous reset mid-CALC
    @(posedge clk); #1;
    funct3 = 3'd5; srca = 32'd100; srcb = 32'd7; rde = 5'd23; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy1}, 32'd0);
    chk("arst_stall", {31'b0, stall1}, 32'd0);
    chk("arst_done", {31'b0, done1}, 32'd0);
    chk("arst_result", res1, 32'd0);
    chk("arst_rd", {27'b0, rd1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1, 3'd5, 32'd9, 32'd3, 5'd24, 32'd3, 34);

    repeat (3) @(posedge clk);
    chk("u1_queue_drained", 32'(q1.size()), 32'd0);
    chk("u4_queue_drained", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
